alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Registered, handshaked successor to the combinational 8-bit ALU.
- Data width is parametrised via WIDTH.
- A sticky carry flag register chains multi-word add-with-carry across transactions, so no external carry_in is needed.
- Valid/ready on input and output; one result register; a saturating invalid-op counter.
- Sits between an instruction sequencer (upstream) and the register-file writeback (downstream).

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_WIDTH, 8, width of the invalid-op counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  opcode/operands valid.
- in_ready  output  1  block can accept an operation this cycle.
- opcode  input  4  operation select (encodings under Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  result.
- carry_out  output  1  carry/rotated-out bit of this result.
- borrow  output  1  borrow of this result.
- zero  output  1  y == 0.
- parity  output  1  XOR-reduce of y (1 = odd number of ones).
- invalid_op  output  1  opcode was unsupported.
- carry_flag  output  1  current sticky carry register.
- err_cnt  output  CNT_WIDTH  saturating count of accepted invalid ops.

Behaviour:
- Reset (async, active-high): out_valid=0, y=0, all result flags=0, carry_flag=0, err_cnt=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An op is accepted on a rising edge where in_valid && in_ready.
  - Result is registered: out_valid rises the cycle after acceptance, so latency is 1 cycle.
  - Throughput is 1 op/cycle while out_ready=1.
  - out_valid clears on out_ready with no new acceptance.
  - y and all flags hold stable while out_valid && !out_ready.
- Opcodes (arithmetic is WIDTH+1 bits; y = low WIDTH bits):
  - 0 INVALID.
  - 1 ADD: a+b. carry_out = bit WIDTH.
  - 2 ADDC: a+b+carry_flag. carry_out = bit WIDTH.
  - 3 SUB: a-b. borrow = (a<b).
  - 4 INC: a+1. carry_out on wrap from all-ones.
  - 5 DEC: a-1. borrow when a==0; y wraps to all-ones.
  - 6 AND: a&b.
  - 7 NOT: ~a.
  - 8 ROL: rotate left by 1. carry_out = a[WIDTH-1].
  - 9 ROR: rotate right by 1. carry_out = a[0].
  - 10-15 INVALID (10 is MUL when the optional feature is enabled).
- Flags not named for an opcode are 0. zero and parity are computed from y for every valid opcode.
- Sticky carry flag:
  - carry_flag <= carry_out on acceptance of ADD, ADDC, INC, ROL or ROR.
  - Unchanged by all other opcodes.
  - Back-to-back ADDC sees the value written by the immediately preceding accepted op.
- Invalid opcode:
  - y=0; carry_out=borrow=zero=parity=0; invalid_op=1.
  - carry_flag unchanged.
  - err_cnt increments and saturates at all-ones.
  - The result is still delivered through the handshake.
- Simultaneous acceptance and output consumption in one cycle: the result register is replaced and out_valid stays 1.
- Reset mid-operation: the pending result is discarded; carry_flag and err_cnt are cleared.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: opcode 10 = MUL.
  - y = low WIDTH bits of a*b.
  - carry_out = 1 if the upper WIDTH bits are nonzero.
  - Updates carry_flag.
  - Latency is unchanged (single cycle).
- Undefined: opcode 10 is INVALID, and no multiplier is synthesised.

Decomposition:
- Package alu_pipe_pkg:
  - opcode localparams OP_INVALID..OP_MUL;
  - function is_valid_op(opcode);
  - function updates_carry(opcode).
- Sub-module alu_core: purely combinational. Takes opcode, a, b and carry_in; produces y and all flags. The top level holds the handshake logic, the result register, carry_flag and err_cnt.

Test Plan (all at WIDTH=8):
- ADD a=9, b=33, out_ready=1 -> next cycle y=42, carry_out=0, zero=0, parity=1, out_valid=1.
- ADD a=200, b=100, then ADDC a=1, b=1 back-to-back -> first y=44, carry_out=1, carry_flag=1; second y=3, carry_flag=0.
- SUB a=65, b=66 -> y=255, borrow=1, parity=0. DEC a=0 -> y=255, borrow=1.
- Backpressure: out_ready=0 with in_valid=1 for 3 cycles -> one result held stable, in_ready=0 after the first acceptance; release out_ready -> next op accepted, no loss or duplication.
- Opcode 12 three times -> invalid_op=1, y=0, err_cnt=3, carry_flag unchanged. Opcode 10: y=a*b low byte with MUL_EN, invalid otherwise.
- Assert reset while out_valid=1 and carry_flag=1 -> out_valid, carry_flag and err_cnt are 0 immediately (asynchronous), before the next clock edge.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
//   Shared opcode encodings and opcode-classification helpers for the
//   registered ALU (alu_pipe) and its combinational datapath (alu_core).
//   Optional feature macro: ALU_PIPE_MUL_EN (opcode 10 becomes MUL).
//   No ports; imported with "import alu_pipe_pkg::*;".
package alu_pipe_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_INVALID = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD     = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADDC    = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_SUB     = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_INC     = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_DEC     = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_AND     = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_NOT     = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_ROL     = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_ROR     = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_MUL     = 4'd10;

  // Opcode 0 and everything above the last implemented opcode are invalid.
  function automatic logic is_valid_op(input logic [OPCODE_W-1:0] op);
`ifdef ALU_PIPE_MUL_EN
    return (op >= OP_ADD) && (op <= OP_MUL);
`else
    return (op >= OP_ADD) && (op <= OP_ROR);
`endif
  endfunction

  // Opcodes whose carry_out is written into the sticky carry register.
  function automatic logic updates_carry(input logic [OPCODE_W-1:0] op);
    logic hit;
    hit = (op == OP_ADD) || (op == OP_ADDC) || (op == OP_INC) ||
          (op == OP_ROL) || (op == OP_ROR);
`ifdef ALU_PIPE_MUL_EN
    hit = hit || (op == OP_MUL);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if
//   Bundles the operation request channel, the result channel and the
//   status outputs of alu_pipe.
//   Request : in_valid, in_ready, opcode, a, b
//   Result  : out_valid, out_ready, y, carry_out, borrow, zero, parity,
//             invalid_op
//   Status  : carry_flag (sticky carry), err_cnt (invalid-op count)
//   Modports: master = sequencer/writeback side, slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  import alu_pipe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;
  logic                 carry_out;
  logic                 borrow;
  logic                 zero;
  logic                 parity;
  logic                 invalid_op;

  logic                 carry_flag;
  logic [CNT_WIDTH-1:0] err_cnt;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, y, carry_out, borrow, zero, parity,
           invalid_op, carry_flag, err_cnt
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, y, carry_out, borrow, zero, parity,
           invalid_op, carry_flag, err_cnt
  );

endinterface

// File: rtl/alu_pipe_core.sv
// alu_core
//   Purely combinational ALU datapath. Arithmetic is done WIDTH+1 bits wide
//   so the carry is the top bit of the sum.
//   Optional feature macro: ALU_PIPE_MUL_EN (adds opcode 10 = MUL).
//   Ports:
//     opcode     in   operation select
//     a, b       in   operands
//     carry_in   in   sticky carry used by ADDC
//     y          out  result (0 for invalid opcodes)
//     carry_out  out  carry / rotated-out bit / MUL high-half-nonzero
//     borrow     out  borrow of SUB / DEC
//     zero       out  y == 0 (valid opcodes only)
//     parity     out  XOR-reduce of y (valid opcodes only)
//     invalid_op out  opcode not supported
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                carry_in,
  output logic [WIDTH-1:0]    y,
  output logic                carry_out,
  output logic                borrow,
  output logic                zero,
  output logic                parity,
  output logic                invalid_op
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] ext_c;
  logic [WIDTH:0] sum;

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = a * b;
`endif

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};
  assign ext_c = {{WIDTH{1'b0}}, carry_in};

  assign invalid_op = !is_valid_op(opcode);

  always_comb begin
    y         = '0;
    carry_out = 1'b0;
    borrow    = 1'b0;
    sum       = '0;
    case (opcode)
      OP_ADD: begin
        sum       = ext_a + ext_b;
        y         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_ADDC: begin
        sum       = ext_a + ext_b + ext_c;
        y         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_SUB: begin
        sum    = ext_a - ext_b;
        y      = sum[WIDTH-1:0];
        borrow = (a < b);
      end
      OP_INC: begin
        sum       = ext_a + (WIDTH+1)'(1);
        y         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_DEC: begin
        sum    = ext_a - (WIDTH+1)'(1);
        y      = sum[WIDTH-1:0];
        borrow = (a == '0);
      end
      OP_AND: y = a & b;
      OP_NOT: y = ~a;
      OP_ROL: begin
        y         = {a[WIDTH-2:0], a[WIDTH-1]};
        carry_out = a[WIDTH-1];
      end
      OP_ROR: begin
        y         = {a[0], a[WIDTH-1:1]};
        carry_out = a[0];
      end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        y         = prod[WIDTH-1:0];
        carry_out = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: begin
        y = '0;
      end
    endcase
  end

  // Invalid results report all flags low, including zero, even though y is 0.
  assign zero   = !invalid_op && (y == '0);
  assign parity = !invalid_op && (^y);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Registered, valid/ready handshaked ALU with a sticky carry register for
//   multi-word add-with-carry chains and a saturating invalid-op counter.
//   One result register, latency 1, throughput 1 op/cycle while out_ready=1.
//   Optional feature macro: ALU_PIPE_MUL_EN (opcode 10 = MUL).
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-high reset
//     bus    alu_pipe_if.slave: request channel (in_valid/in_ready/opcode/
//            a/b), result channel (out_valid/out_ready/y + flags) and
//            status (carry_flag, err_cnt)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);

  logic [WIDTH-1:0]     core_y;
  logic                 core_carry;
  logic                 core_borrow;
  logic                 core_zero;
  logic                 core_parity;
  logic                 core_invalid;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     y_q;
  logic                 carry_out_q;
  logic                 borrow_q;
  logic                 zero_q;
  logic                 parity_q;
  logic                 invalid_q;
  logic                 carry_flag_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  logic                 in_ready;
  logic                 accept;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode     (bus.opcode),
    .a          (bus.a),
    .b          (bus.b),
    .carry_in   (carry_flag_q),
    .y          (core_y),
    .carry_out  (core_carry),
    .borrow     (core_borrow),
    .zero       (core_zero),
    .parity     (core_parity),
    .invalid_op (core_invalid)
  );

  // The result register is free when empty or being drained this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_out_q <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      invalid_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      y_q         <= core_y;
      carry_out_q <= core_carry;
      borrow_q    <= core_borrow;
      zero_q      <= core_zero;
      parity_q    <= core_parity;
      invalid_q   <= core_invalid;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Written at acceptance, so a back-to-back ADDC sees the previous op's carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_flag_q <= 1'b0;
    end else if (accept && updates_carry(bus.opcode)) begin
      carry_flag_q <= core_carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (accept && core_invalid && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.y          = y_q;
  assign bus.carry_out  = carry_out_q;
  assign bus.borrow     = borrow_q;
  assign bus.zero       = zero_q;
  assign bus.parity     = parity_q;
  assign bus.invalid_op = invalid_q;
  assign bus.carry_flag = carry_flag_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  logic clk;
  logic reset;

  alu_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  alu_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       c;
    logic       bo;
    logic       z;
    logic       p;
    logic       cf;
  } vec_t;

  vec_t vecs [16];

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  initial begin
    // opcode a b | y c borrow zero parity carry_flag (cf tracked through the list)
    vecs[0]  = '{OP_ADD,  8'd9,   8'd33,  8'd42,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_ADD,  8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{OP_ADDC, 8'd1,   8'd1,   8'd3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SUB,  8'd65,  8'd66,  8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_DEC,  8'd0,   8'd0,   8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_INC,  8'd255, 8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{OP_ADDC, 8'd255, 8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{OP_AND,  8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_NOT,  8'h0F,  8'h00,  8'hF0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_ROL,  8'h81,  8'h00,  8'h03,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{OP_ROR,  8'h02,  8'h00,  8'h01,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_SUB,  8'd66,  8'd65,  8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_DEC,  8'd1,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{OP_ADD,  8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_INC,  8'h7F,  8'd0,   8'h80,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{OP_ADDC, 8'd10,  8'd20,  8'd30,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = OP_INVALID;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset out_valid",  int'(bus.out_valid),  0);
    chk("reset y",          int'(bus.y),          0);
    chk("reset carry_flag", int'(bus.carry_flag), 0);
    chk("reset err_cnt",    int'(bus.err_cnt),    0);
    chk("reset in_ready",   int'(bus.in_ready),   1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back table, one op per cycle with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i),  int'(bus.out_valid),  1);
      chk($sformatf("v%0d y", i),          int'(bus.y),          int'(vecs[i].y));
      chk($sformatf("v%0d carry_out", i),  int'(bus.carry_out),  int'(vecs[i].c));
      chk($sformatf("v%0d borrow", i),     int'(bus.borrow),     int'(vecs[i].bo));
      chk($sformatf("v%0d zero", i),       int'(bus.zero),       int'(vecs[i].z));
      chk($sformatf("v%0d parity", i),     int'(bus.parity),     int'(vecs[i].p));
      chk($sformatf("v%0d invalid_op", i), int'(bus.invalid_op), 0);
      chk($sformatf("v%0d carry_flag", i), int'(bus.carry_flag), int'(vecs[i].cf));
      chk($sformatf("v%0d err_cnt", i),    int'(bus.err_cnt),    0);
    end

    // Set carry_flag, then invalid opcodes must leave it alone.
    drive(OP_ADD, 8'd200, 8'd100);
    @(posedge clk);
    @(negedge clk);
    chk("pre-inv carry_flag", int'(bus.carry_flag), 1);
    for (int i = 1; i <= 3; i++) begin
      drive(4'd12, 8'd7, 8'd9);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("inv%0d invalid_op", i), int'(bus.invalid_op), 1);
      chk($sformatf("inv%0d y", i),          int'(bus.y),          0);
      chk($sformatf("inv%0d flags", i),
          int'({bus.carry_out, bus.borrow, bus.zero, bus.parity}), 0);
      chk($sformatf("inv%0d out_valid", i),  int'(bus.out_valid),  1);
      chk($sformatf("inv%0d carry_flag", i), int'(bus.carry_flag), 1);
      chk($sformatf("inv%0d err_cnt", i),    int'(bus.err_cnt),    i);
    end

    // Opcode 10: 20*13 = 260 -> low byte 4, high byte nonzero.
    drive(4'd10, 8'd20, 8'd13);
    @(posedge clk);
    @(negedge clk);
`ifdef ALU_PIPE_MUL_EN
    chk("mul y",          int'(bus.y),          4);
    chk("mul carry_out",  int'(bus.carry_out),  1);
    chk("mul invalid_op", int'(bus.invalid_op), 0);
    chk("mul err_cnt",    int'(bus.err_cnt),    3);
`else
    chk("op10 y",          int'(bus.y),          0);
    chk("op10 invalid_op", int'(bus.invalid_op), 1);
    chk("op10 err_cnt",    int'(bus.err_cnt),    4);
`endif
    chk("op10 carry_flag", int'(bus.carry_flag), 1);

    // Saturation of the invalid-op counter.
    for (int i = 0; i < 260; i++) begin
      drive(OP_INVALID, 8'd0, 8'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("err_cnt saturated", int'(bus.err_cnt), 255);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drain out_valid", int'(bus.out_valid), 0);

    // Backpressure: one result held, no loss, no duplication.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'd1, 8'd2);
    chk("bp in_ready empty", int'(bus.in_ready), 1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(OP_ADD, 8'd5, 8'd6);
      chk($sformatf("bp%0d out_valid", i), int'(bus.out_valid), 1);
      chk($sformatf("bp%0d y", i),         int'(bus.y),         3);
      chk($sformatf("bp%0d in_ready", i),  int'(bus.in_ready),  0);
      if (i < 2) @(posedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp next y",         int'(bus.y),         11);
    chk("bp next out_valid", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp consumed out_valid", int'(bus.out_valid), 0);

    // Asynchronous reset while a result is pending and carry_flag is set.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 8'd200, 8'd100);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-rst out_valid",  int'(bus.out_valid),  1);
    chk("pre-rst carry_flag", int'(bus.carry_flag), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst out_valid",  int'(bus.out_valid),  0);
    chk("async rst carry_flag", int'(bus.carry_flag), 0);
    chk("async rst err_cnt",    int'(bus.err_cnt),    0);
    chk("async rst y",          int'(bus.y),          0);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post-rst out_valid", int'(bus.out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
